// File: rtl/ifetch_mem_responder_if.sv
// Request/response bus between the fetch unit and its memory responder,
// plus the word-read port into the simulated physical memory.
interface ifetch_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Handshake: a beat transfers on a rising edge where valid && ready; the
  // sender holds valid and payload stable until that edge, and ready may
  // depend on the receiver's state only. pmem_rd is a single-cycle strobe
  // that reads the word at pmem_addr; pmem_rdata answers in the same cycle.
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  pmem_rd;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [DATA_WIDTH-1:0] pmem_rdata;

  modport master (
    output req_valid, req_addr, rsp_ready, pmem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, pmem_rd, pmem_addr
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, pmem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, pmem_rd, pmem_addr
  );
endinterface

// File: rtl/ifetch_mem_responder.sv
// Single-outstanding instruction-fetch memory responder with fixed latency.
// Define IFETCH_RAND_DELAY_EN to add 0..3 LFSR-chosen extra wait cycles.
module ifetch_mem_responder #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           LATENCY    = 1,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 32'h0800_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  ifetch_mem_responder_if.slave       bus,
  output logic [1:0]                  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int unsigned         CNT_W   = 5;
  localparam logic [CNT_W-1:0]    LAT_CNT = CNT_W'(LATENCY);
  // One extra bit keeps MEM_BASE+MEM_SIZE from wrapping at the top of memory.
  localparam logic [ADDR_WIDTH:0] LIMIT   = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, load_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, cap_addr;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;
  logic                    enter_resp;
  logic                    addr_bad;

`ifdef IFETCH_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign load_cnt = LAT_CNT + {3'b000, lfsr_q[1:0]};
`else
  assign load_cnt = LAT_CNT;
`endif

  // With zero wait cycles the word is fetched on the accept edge itself,
  // before the address has been latched.
  assign cap_addr = (state_q == S_IDLE) ? bus.req_addr : addr_q;
  assign addr_bad = (cap_addr[1:0] != 2'b00) || (cap_addr < MEM_BASE) ||
                    ({1'b0, cap_addr} >= LIMIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          if (load_cnt == '0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = load_cnt;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d  = addr_bad;
      data_d = addr_bad ? '0 : bus.pmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.pmem_rd   = enter_resp && !addr_bad && !rst;
  assign bus.pmem_addr = cap_addr;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Bench for ifetch_mem_responder: three responders (LATENCY 0, 1, 4) checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_ifetch_mem_responder;

  logic        clk;
  logic        rst;
  int          cyc;
  bit          chk_en;
  int          total;
  int          bad;

  logic        rv    [3];
  logic [31:0] ra    [3];
  logic        rr    [3];
  logic        rdy   [3];
  logic        vld   [3];
  logic        err   [3];
  logic        rd    [3];
  logic [31:0] dat   [3];
  logic [31:0] paddr [3];
  logic [1:0]  st    [3];

`ifdef IFETCH_RAND_DELAY_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory contents ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic bit addr_err(input logic [31:0] a);
    longint unsigned ua;
    ua = 64'(a);
    return (ua % 4 != 0) || (ua < 64'h8000_0000) || (ua >= 64'h8800_0000);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 4);
  endfunction

  // ---------------- DUTs ----------------
  ifetch_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  ifetch_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  ifetch_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();

  ifetch_mem_responder #(.LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0), .state_o(st[0]));
  ifetch_mem_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1), .state_o(st[1]));
  ifetch_mem_responder #(.LATENCY(4)) dut2 (.clk(clk), .rst(rst), .bus(b2), .state_o(st[2]));

  assign b0.req_valid  = rv[0];
  assign b0.req_addr   = ra[0];
  assign b0.rsp_ready  = rr[0];
  assign b0.pmem_rdata = mem_word(b0.pmem_addr);
  assign rdy[0]   = b0.req_ready;
  assign vld[0]   = b0.rsp_valid;
  assign dat[0]   = b0.rsp_data;
  assign err[0]   = b0.rsp_err;
  assign rd[0]    = b0.pmem_rd;
  assign paddr[0] = b0.pmem_addr;

  assign b1.req_valid  = rv[1];
  assign b1.req_addr   = ra[1];
  assign b1.rsp_ready  = rr[1];
  assign b1.pmem_rdata = mem_word(b1.pmem_addr);
  assign rdy[1]   = b1.req_ready;
  assign vld[1]   = b1.rsp_valid;
  assign dat[1]   = b1.rsp_data;
  assign err[1]   = b1.rsp_err;
  assign rd[1]    = b1.pmem_rd;
  assign paddr[1] = b1.pmem_addr;

  assign b2.req_valid  = rv[2];
  assign b2.req_addr   = ra[2];
  assign b2.rsp_ready  = rr[2];
  assign b2.pmem_rdata = mem_word(b2.pmem_addr);
  assign rdy[2]   = b2.req_ready;
  assign vld[2]   = b2.rsp_valid;
  assign dat[2]   = b2.rsp_data;
  assign err[2]   = b2.rsp_err;
  assign rd[2]    = b2.pmem_rd;
  assign paddr[2] = b2.pmem_addr;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // ---------------- transaction model ----------------
  bit          m_busy  [3];
  bit          m_vseen [3];
  int          m_acc   [3];
  logic [31:0] m_addr  [3];
  logic [31:0] m_edat  [3];
  logic        m_eerr  [3];
  logic [31:0] m_ldat  [3];
  logic        m_lerr  [3];
  int          m_rd    [3];
  int          rd_total[3];

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit exp_rdy;
      bit exp_v;
      bit vchk;
      int due;
      exp_rdy = !m_busy[k] && !rst;
      chk($sformatf("req_ready[%0d]", k), 32'(rdy[k]), 32'(exp_rdy));
      if (rd[k]) begin
        m_rd[k]++;
        rd_total[k]++;
        chk($sformatf("pmem_addr[%0d]", k), paddr[k], m_busy[k] ? m_addr[k] : ra[k]);
      end
      if (!m_busy[k]) begin
        chk($sformatf("rsp_valid_idle[%0d]", k), 32'(vld[k]), 32'd0);
        chk($sformatf("rsp_data_hold[%0d]", k), dat[k], m_ldat[k]);
        chk($sformatf("rsp_err_hold[%0d]", k), 32'(err[k]), 32'(m_lerr[k]));
        chk($sformatf("state_idle[%0d]", k), 32'(st[k]), 32'd0);
      end else begin
        due  = m_acc[k] + lat_of(k);
        vchk = 1'b1;
        if (m_vseen[k])              exp_v = 1'b1;
        else if (cyc < due)          exp_v = 1'b0;
        else if (cyc >= due + EXTRA) exp_v = 1'b1;
        else begin
          vchk  = 1'b0;
          exp_v = vld[k];
        end
        if (vchk) chk($sformatf("rsp_valid[%0d]", k), 32'(vld[k]), 32'(exp_v));
        if (vld[k] && exp_v) begin
          if (!m_vseen[k]) begin
            chk($sformatf("pmem_reads[%0d]", k), m_rd[k], m_eerr[k] ? 32'd0 : 32'd1);
            m_vseen[k] = 1'b1;
          end
          chk($sformatf("rsp_data[%0d]", k), dat[k], m_edat[k]);
          chk($sformatf("rsp_err[%0d]", k), 32'(err[k]), 32'(m_eerr[k]));
        end else begin
          chk($sformatf("rsp_data_wait[%0d]", k), dat[k], m_ldat[k]);
          chk($sformatf("rsp_err_wait[%0d]", k), 32'(err[k]), 32'(m_lerr[k]));
        end
      end
      // predict the effect of the coming edge
      if (rst) begin
        if (m_busy[k] && !m_vseen[k]) chk($sformatf("dropped_reads[%0d]", k), m_rd[k], 32'd0);
        m_busy[k]  = 1'b0;
        m_vseen[k] = 1'b0;
        m_ldat[k]  = '0;
        m_lerr[k]  = 1'b0;
        m_rd[k]    = 0;
      end else if (!m_busy[k]) begin
        if (rv[k] && exp_rdy) begin
          m_busy[k] = 1'b1;
          m_acc[k]  = cyc + 1;
          m_addr[k] = ra[k];
          m_eerr[k] = addr_err(ra[k]);
          m_edat[k] = m_eerr[k] ? 32'd0 : mem_word(ra[k]);
        end
      end else if (m_vseen[k] && rr[k]) begin
        m_busy[k]  = 1'b0;
        m_vseen[k] = 1'b0;
        m_ldat[k]  = m_edat[k];
        m_lerr[k]  = m_eerr[k];
        m_rd[k]    = 0;
      end
    end
  endtask

  initial begin : compare
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 1'b0; m_vseen[k] = 1'b0; m_acc[k] = 0; m_addr[k] = '0;
      m_edat[k] = '0; m_eerr[k] = 1'b0; m_ldat[k] = '0; m_lerr[k] = 1'b0;
      m_rd[k] = 0; rd_total[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (chk_en) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_drive(input bit rnd);
    @(posedge clk);
    #1;
    if (rnd) for (int j = 0; j < 3; j++) rr[j] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_req(input int k, input logic [31:0] a, input bit rnd);
    int n;
    tick_drive(rnd);
    rv[k] = 1'b1;
    ra[k] = a;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (rdy[k]) break;
      n++;
      if (n > 40) begin
        fail($sformatf("accept_timeout[%0d]", k));
        break;
      end
      tick_drive(rnd);
    end
    tick_drive(rnd);
    rv[k] = 1'b0;
    ra[k] = 32'h1234_5677;
  endtask

  task automatic wait_hs(input int k, input bit rnd, output logic [31:0] d, output logic e);
    int n;
    n = 0;
    d = '0;
    e = 1'b0;
    while (1) begin
      @(negedge clk);
      if (vld[k] && rr[k]) begin
        d = dat[k];
        e = err[k];
        break;
      end
      n++;
      if (n > 60) begin
        fail($sformatf("response_timeout[%0d]", k));
        break;
      end
      tick_drive(rnd);
    end
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (vld[k]) break;
      n++;
      if (n > 60) begin
        fail($sformatf("valid_timeout[%0d]", k));
        break;
      end
    end
  endtask

  task automatic req_get(input int k, input logic [31:0] a, input bit rnd,
                         output logic [31:0] d, output logic e);
    do_req(k, a, rnd);
    wait_hs(k, rnd, d, e);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] d;
    logic        e;
    logic [31:0] a;
    logic [31:0] d0;
    int          n;
    int          rd_before;
    int          pick;
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0;
      ra[k] = '0;
      rr[k] = 1'b1;
    end
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_state[%0d]", k), 32'(st[k]), 32'd0);
      chk($sformatf("reset_valid[%0d]", k), 32'(vld[k]), 32'd0);
      chk($sformatf("reset_data[%0d]", k), dat[k], 32'd0);
      chk($sformatf("reset_ready[%0d]", k), 32'(rdy[k]), 32'd1);
    end

`ifndef IFETCH_RAND_DELAY_EN
    // basic read, LATENCY=1, cycle-exact
    tick_drive(0);
    rv[1] = 1'b1;
    ra[1] = 32'h8000_0000;
    @(negedge clk);
    chk("basic_c0_ready", 32'(rdy[1]), 32'd1);
    tick_drive(0);
    rv[1] = 1'b0;
    ra[1] = 32'h1234_5677;
    @(negedge clk);
    chk("basic_c1_ready", 32'(rdy[1]), 32'd0);
    chk("basic_c1_valid", 32'(vld[1]), 32'd0);
    @(negedge clk);
    chk("basic_c2_valid", 32'(vld[1]), 32'd1);
    chk("basic_c2_data", dat[1], 32'h0000_0413);
    chk("basic_c2_err", 32'(err[1]), 32'd0);
    @(negedge clk);
    chk("basic_c3_ready", 32'(rdy[1]), 32'd1);
    chk("basic_c3_valid", 32'(vld[1]), 32'd0);
    chk("basic_c3_data_held", dat[1], 32'h0000_0413);

    // zero latency with a request held high: one response every 2 cycles
    tick_drive(0);
    rv[0] = 1'b1;
    ra[0] = 32'h8000_0004;
    @(negedge clk);
    chk("zl_ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    chk("zl_valid", 32'(vld[0]), 32'd1);
    chk("zl_data", dat[0], 32'h0004_FFFB);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (vld[0]) n++;
    end
    chk("zl_b2b_count", n, 32'd5);
    tick_drive(0);
    rv[0] = 1'b0;
    repeat (2) tick_drive(0);
`else
    req_get(1, 32'h8000_0000, 0, d, e);
    chk("basic_data", d, 32'h0000_0413);
    chk("basic_err", 32'(e), 32'd0);
    req_get(0, 32'h8000_0004, 0, d, e);
    chk("zl_data", d, 32'h0004_FFFB);
`endif

    // backpressure on the LATENCY=1 responder
    tick_drive(0);
    rr[1] = 1'b0;
    rd_before = rd_total[1];
    do_req(1, 32'h8000_0040, 0);
    wait_valid(1);
    d0 = dat[1];
    chk("bp_data", d0, 32'h0040_FFBF);
    repeat (5) begin
      tick_drive(0);
      @(negedge clk);
      chk("bp_valid_held", 32'(vld[1]), 32'd1);
      chk("bp_data_stable", dat[1], d0);
      chk("bp_ready_low", 32'(rdy[1]), 32'd0);
    end
    tick_drive(0);
    rr[1] = 1'b1;
    @(negedge clk);
    tick_drive(0);
    @(negedge clk);
    chk("bp_released", 32'(vld[1]), 32'd0);
    chk("bp_read_count", rd_total[1] - rd_before, 32'd1);

    // address error boundaries
    req_get(1, 32'h8000_0002, 0, d, e);
    chk("err_misaligned", 32'(e), 32'd1);
    chk("err_misaligned_data", d, 32'd0);
    req_get(1, 32'h7FFF_FFFC, 0, d, e);
    chk("err_below_base", 32'(e), 32'd1);
    req_get(1, 32'h87FF_FFFC, 0, d, e);
    chk("ok_last_word", 32'(e), 32'd0);
    chk("ok_last_word_data", d, 32'hFFFC_0003);
    req_get(1, 32'h8800_0000, 0, d, e);
    chk("err_past_end", 32'(e), 32'd1);
    req_get(2, 32'h8000_0100, 0, d, e);
    chk("lat4_data", d, 32'h0100_FEFF);

    // reset during the second WAIT cycle of the LATENCY=4 responder
    tick_drive(0);
    rv[2] = 1'b1;
    ra[2] = 32'h8000_0200;
    @(negedge clk);
    chk("rst_mid_accept", 32'(rdy[2]), 32'd1);
    tick_drive(0);
    rv[2] = 1'b0;
    tick_drive(0);
    rst = 1'b1;
    tick_drive(0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", 32'(st[2]), 32'd0);
    chk("rst_mid_valid", 32'(vld[2]), 32'd0);
    chk("rst_mid_ready", 32'(rdy[2]), 32'd1);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (vld[2]) n++;
    end
    chk("rst_mid_no_response", n, 32'd0);

    // random rsp_ready, mixed addresses, round-robin over the responders
    for (int i = 0; i < 100; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 6)       a = 32'h8000_0000 + (32'($urandom_range(0, 1023)) << 2);
      else if (pick == 6) a = 32'h87FF_FFFC;
      else if (pick == 7) a = 32'h8000_0001 + (32'($urandom_range(0, 255)) << 2);
      else if (pick == 8) a = 32'h7FFF_FFFC;
      else                a = 32'h8800_0000;
      req_get(i % 3, a, 1, d, e);
    end
    tick_drive(0);
    for (int k = 0; k < 3; k++) rr[k] = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_mem_responder.md
Name: ifetch_mem_responder

Overview:
- Memory-side responder for the instruction-fetch channel.
- Accepts one fetch request at a time over a valid/ready request channel.
- Waits a configurable number of cycles, then reads the 32-bit word from simulated physical memory via the `pmem_read` DPI-C function.
- Returns the word, plus an error flag, over a valid/ready response channel. It is the memory endpoint the fetch unit talks to once fetch becomes multi-cycle.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, response data width; only 32 is supported.
- LATENCY, 1, wait cycles between request acceptance and response; range 0..15.
- MEM_BASE, 32'h8000_0000, lowest valid address (equals `MBASE`).
- MEM_SIZE, 32'h0800_0000, size of the valid window in bytes.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  fetch request present
- req_ready  output  1  responder can accept a request
- req_addr  input  ADDR_WIDTH  byte address of the instruction
- rsp_valid  output  1  response data valid
- rsp_ready  input  1  fetch side accepts the response
- rsp_data  output  DATA_WIDTH  instruction word
- rsp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset: clk/rst as decided above — one clock, synchronous active-high reset.
  - On any edge with rst=1: state to IDLE, counter to 0, rsp_valid=0, rsp_data=0, rsp_err=0, latched address to 0.
  - req_ready=0 while rst=1.
  - Reset mid-transaction drops the request silently; no `pmem_read` call is made for it.
- State machine: IDLE, WAIT, RESP.
  - Only one request is outstanding at a time.
  - req_ready = (state==IDLE) && !rst, driven combinationally from state.
- IDLE:
  - Accept happens when req_valid && req_ready at an edge.
  - On accept, latch req_addr and load cnt=LATENCY.
  - If LATENCY==0, go directly to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1, go to RESP on the next edge.
- Timing: a request accepted at edge N gives rsp_valid=1 from the cycle after edge N+LATENCY.
- Data capture, at the edge entering RESP:
  - If addr[1:0]!=0, or addr<MEM_BASE, or addr>=MEM_BASE+MEM_SIZE: rsp_err=1, rsp_data=0, and no DPI call.
  - Otherwise: rsp_err=0 and rsp_data=pmem_read(addr), called exactly once per transaction.
  - Compute the range check in ADDR_WIDTH+1 bits so MEM_BASE+MEM_SIZE does not wrap.
- RESP:
  - rsp_valid=1.
  - rsp_data and rsp_err stay stable until the handshake.
  - On rsp_valid && rsp_ready: go to IDLE, rsp_valid=0 next cycle.
  - rsp_data holds its last value after the handshake.
- Throughput: at most one response per LATENCY+2 cycles. No accept in the same cycle as a response handshake.
- req_addr is ignored outside the IDLE accept edge.

Optional Feature:
- Macro: IFETCH_RAND_DELAY_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 at reset, steps every cycle.
  - At accept, cnt is loaded with LATENCY + lfsr[1:0] instead of LATENCY, adding 0..3 extra wait cycles.
  - All handshake rules are unchanged; the response is held until rsp_ready with random latency too.
- When undefined: no LFSR is present and latency is exactly LATENCY.

Test Plan:
- Basic read: LATENCY=1, pmem word at 0x8000_0000 = 0x0000_0413, rsp_ready=1. Request 0x8000_0000 at cycle 0 -> req_ready=0 in cycle 1, rsp_valid=1 in cycle 2 with rsp_data=0x0000_0413, rsp_err=0, back to IDLE in cycle 3.
- Zero latency: LATENCY=0, request 0x8000_0004 -> rsp_valid=1 in the very next cycle with the memory word. Back-to-back requests are accepted every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid and rsp_data stay constant, req_ready=0 throughout. Exactly one DPI read is counted.
- Errors:
  - Address 0x8000_0002 -> rsp_err=1, rsp_data=0.
  - Address 0x7FFF_FFFC -> rsp_err=1.
  - Address 0x87FF_FFFC -> rsp_err=0.
  - Address 0x8800_0000 -> rsp_err=1.
- Reset mid-operation: LATENCY=4, assert rst in the 2nd WAIT cycle -> next cycle rsp_valid=0, state IDLE. req_ready=1 once rst falls. No response is ever issued for the dropped address.
- IFETCH_RAND_DELAY_EN defined: 100 requests with random rsp_ready -> every response latency lies in LATENCY..LATENCY+3 and the data order matches the request order.
